// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline register with a 2-entry skid buffer.
//
// Sits between pipeline stages and carries a DATA_W payload plus a TAG_W destination
// tag with valid/ready handshakes on both sides. Upstream ready comes straight from a
// register, so out_ready never reaches in_ready combinationally. A synchronous flush
// kills every held entry and presents the bubble values.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream entry valid
//   in_ready   block can accept an entry this cycle (registered)
//   in_data    upstream payload
//   in_tag     upstream tag
//   out_valid  output entry valid
//   out_ready  downstream accepts this cycle
//   out_data   output payload (registered)
//   out_tag    output tag (registered)
//   occupancy  entries held, 0..2 (registered)
//
// Optional feature, macro PIPE_SKID_PERF_CNT_EN:
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   bubble_cnt saturating count of flushes that discard at least one entry
module pipe_skid_reg #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       TAG_W       = 8,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter logic [TAG_W-1:0]  BUBBLE_TAG  = TAG_W'('hF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
`ifdef PIPE_SKID_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            stateQ, stateD;
  logic [DATA_W-1:0] mainDataQ, mainDataD, skidDataQ, skidDataD;
  logic [TAG_W-1:0]  mainTagQ, mainTagD, skidTagQ, skidTagD;
  logic              inReadyQ, inReadyD;
  logic              outValidQ, outValidD;
  logic [1:0]        occQ, occD;
  logic              accept, pop;

  assign accept = in_valid & inReadyQ;
  assign pop    = outValidQ & out_ready;

  always_comb begin
    stateD    = stateQ;
    mainDataD = mainDataQ;
    mainTagD  = mainTagQ;
    skidDataD = skidDataQ;
    skidTagD  = skidTagQ;

    case (stateQ)
      StEmpty: begin
        if (accept) begin
          stateD    = StOne;
          mainDataD = in_data;
          mainTagD  = in_tag;
        end
      end
      StOne: begin
        if (accept && !pop) begin
          stateD    = StFull;
          skidDataD = in_data;
          skidTagD  = in_tag;
        end else if (accept && pop) begin
          mainDataD = in_data;
          mainTagD  = in_tag;
        end else if (pop) begin
          stateD    = StEmpty;
          mainDataD = BUBBLE_DATA;
          mainTagD  = BUBBLE_TAG;
        end
      end
      StFull: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          stateD    = StOne;
          mainDataD = skidDataQ;
          mainTagD  = skidTagQ;
        end
      end
      default: begin
        stateD    = StEmpty;
        mainDataD = BUBBLE_DATA;
        mainTagD  = BUBBLE_TAG;
      end
    endcase

    // Flush wins over everything: any accept this cycle is killed, a pop still counts.
    if (flush) begin
      stateD    = StEmpty;
      mainDataD = BUBBLE_DATA;
      mainTagD  = BUBBLE_TAG;
    end

    inReadyD  = (stateD != StFull);
    outValidD = (stateD != StEmpty);
    case (stateD)
      StOne:   occD = 2'd1;
      StFull:  occD = 2'd2;
      default: occD = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= StEmpty;
      mainDataQ <= BUBBLE_DATA;
      mainTagQ  <= BUBBLE_TAG;
      skidDataQ <= BUBBLE_DATA;
      skidTagQ  <= BUBBLE_TAG;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      occQ      <= 2'd0;
    end else begin
      stateQ    <= stateD;
      mainDataQ <= mainDataD;
      mainTagQ  <= mainTagD;
      skidDataQ <= skidDataD;
      skidTagQ  <= skidTagD;
      inReadyQ  <= inReadyD;
      outValidQ <= outValidD;
      occQ      <= occD;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_data  = mainDataQ;
  assign out_tag   = mainTagQ;
  assign occupancy = occQ;

`ifdef PIPE_SKID_PERF_CNT_EN
  logic [15:0] stallCntQ, bubbleCntQ;
  logic [2:0]  lostN;

  // Entries killed by a flush: held ones not popped, plus one accepted alongside it.
  assign lostN = 3'(occQ) - 3'(pop) + 3'(accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ  <= '0;
      bubbleCntQ <= '0;
    end else begin
      if (outValidQ && !out_ready && (stallCntQ != 16'hFFFF)) begin
        stallCntQ <= stallCntQ + 16'd1;
      end
      if (flush && (lostN != 3'd0) && (bubbleCntQ != 16'hFFFF)) begin
        bubbleCntQ <= bubbleCntQ + 16'd1;
      end
    end
  end

  assign stall_cnt  = stallCntQ;
  assign bubble_cnt = bubbleCntQ;
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, elastic pipeline register that replaces the fixed stage registers between decode, execute and memory stages.
- Carries a DATA_W payload plus a TAG_W destination tag, with a valid/ready handshake in both directions.
- Contains a 2-entry skid buffer, so upstream ready is fully registered and there is no combinational ready path.
- Provides synchronous flush that injects a bubble (BUBBLE_DATA, BUBBLE_TAG) for branch mispredict and hazard recovery.

Parameters:
- DATA_W, 32, payload width in bits (valE/valA-style word).
- TAG_W, 8, tag width in bits (dstW register id).
- BUBBLE_DATA, 0, payload presented while out_valid=0 and after flush/reset.
- BUBBLE_TAG, 8'hF, tag presented while empty (F = no register).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry this cycle (registered).
- in_data  in  DATA_W  upstream payload.
- in_tag  in  TAG_W  upstream tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  output payload (registered).
- out_tag  out  TAG_W  output tag (registered).
- occupancy  out  2  entries held, 0..2.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=BUBBLE_DATA, out_tag=BUBBLE_TAG, skid entry empty, in_ready=1, occupancy=0. Counters under PERF_CNT_EN are cleared. Reset mid-transfer discards every entry.
- Accept: in_valid & in_ready at the edge. Pop: out_valid & out_ready at the edge.
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- EMPTY: accept -> ONE; the entry appears on out_* the next cycle (latency 1).
- ONE:
  - Accept with no pop -> FULL (entry goes to skid).
  - Pop with no accept -> EMPTY.
  - Accept with pop -> ONE (new entry goes into main).
- FULL: in_ready=0. Pop -> ONE (skid moves to main). Accept is impossible.
- in_ready = !(state==FULL), taken from a register. It must not depend combinationally on out_ready.
- Order is preserved (strict FIFO). No entry is dropped or duplicated.
- out_data/out_tag change only on pop, accept-into-empty, flush or reset. They hold while out_valid & !out_ready.
- When out_valid=0, out_data/out_tag equal BUBBLE_DATA/BUBBLE_TAG.
- flush=1 at edge:
  - Next state is EMPTY; out_* load bubble values.
  - An accept in the same cycle is discarded. in_ready still reflects the pre-flush state, so upstream sees the handshake but the entry is killed.
  - A pop in the same cycle completes for the downstream (the entry was consumed). The block then becomes EMPTY.
- occupancy = 0/1/2 per state, registered.

Optional Feature:
- Macro: PIPE_SKID_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0]: increments each cycle with out_valid & !out_ready.
  - Adds output bubble_cnt [15:0]: increments on each flush that discards at least one entry.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each; in_ready stays 1; occupancy stays 1.
- Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0. Then raise out_ready -> out 0xA then 0xB in order, and in_ready returns to 1 one cycle after the first pop.
- Flush when FULL: hold 0x11/tag 3 and 0x22/tag 4, assert flush with in_valid=1 data 0x33 -> next cycle out_valid=0, out_data=0, out_tag=0xF, occupancy=0; 0x33 is never output.
- Simultaneous accept+pop in ONE: hold 0x5, push 0x6 with out_ready=1 -> next cycle out_data=0x6, occupancy=1.
- Async reset mid-stream: assert rst between edges while FULL -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- With PIPE_SKID_PERF_CNT_EN: 5 cycles of out_valid & !out_ready, then one flush of a FULL stage -> stall_cnt=5, bubble_cnt=1; a flush while EMPTY leaves bubble_cnt=1.
